// File: rtl/dps_w23_pkg.sv
// Shared constants for the 23-bit DPS code: widths and the per-bit weight table.
// The weights follow the Fibonacci numeral system (FNSk = k-th Fibonacci number).
package dps_w23_pkg;

   localparam int CW_W    = 23;
   localparam int DBLEN23 = 16;
   localparam int ACC_W   = DBLEN23 + 2;

   typedef logic [ACC_W-1:0] acc_t;

   // Bit 21 carries twice FNS22 and bit 22 carries FNS23.
   localparam acc_t W23 [0:CW_W-1] = '{
      acc_t'(1),     acc_t'(1),     acc_t'(2),     acc_t'(3),
      acc_t'(5),     acc_t'(8),     acc_t'(13),    acc_t'(21),
      acc_t'(34),    acc_t'(55),    acc_t'(89),    acc_t'(144),
      acc_t'(233),   acc_t'(377),   acc_t'(610),   acc_t'(987),
      acc_t'(1597),  acc_t'(2584),  acc_t'(4181),  acc_t'(6765),
      acc_t'(10946), acc_t'(35422), acc_t'(28657)
   };

endpackage

// File: rtl/dps_wsum_slice.sv
// Combinational partial sum of BPC code bits starting at code index base.
// Indices past the top of the codeword contribute nothing.
module dps_wsum_slice
   import dps_w23_pkg::*;
#(
   parameter int BPC = 4
) (
   input  logic [BPC-1:0]   bits,
   input  logic [5:0]       base,
   output logic [ACC_W-1:0] psum
);

   logic [5:0] idx;

   always_comb begin
      psum = '0;
      idx  = '0;
      for (int j = 0; j < BPC; j++) begin
         idx = base + 6'(j);
         if (bits[j] && (idx < 6'(CW_W))) begin
            psum = psum + W23[idx[4:0]];
         end
      end
   end

endmodule

// File: rtl/dps_decoder_23.sv
// DPS codeword decoder: iterative weighted sum of the 23 code bits, BPC bits per cycle,
// with valid/ready handshakes on both sides and an out-of-range flag.
//
//   state | meaning
//   IDLE  | waiting for a codeword, in_ready=1
//   BUSY  | accumulating BPC weighted bits per cycle
//   DONE  | result held on dataout/code_err until out_ready
module dps_decoder_23
   import dps_w23_pkg::*;
#(
   parameter int BPC = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CW_W-1:0]    codein,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DBLEN23-1:0] dataout,
   output logic               code_err
);

   localparam int NITER = (CW_W + BPC - 1) / BPC;
   localparam int IT_W  = $clog2(NITER + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW_W-1:0]  code_q, code_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [5:0]       idx_q, idx_d;
   logic [IT_W-1:0]  iter_q, iter_d;

   logic [CW_W-1:0]  code_sh;
   logic [BPC-1:0]   slice_bits;
   logic [ACC_W-1:0] psum;

   // The shadow codeword stays put; the active window is selected by shifting a copy.
   assign code_sh    = code_q >> idx_q;
   assign slice_bits = code_sh[BPC-1:0];

   dps_wsum_slice #(.BPC(BPC)) u_slice (
      .bits (slice_bits),
      .base (idx_q),
      .psum (psum)
   );

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      iter_d  = iter_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               code_d  = codein;
               acc_d   = '0;
               idx_d   = '0;
               iter_d  = IT_W'(NITER - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = acc_q + psum;
            idx_d = idx_q + 6'(BPC);
            if (iter_q == '0) begin
               state_d = DONE;
            end else begin
               iter_d = iter_q - IT_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         acc_q   <= '0;
         idx_q   <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         iter_q  <= iter_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   // Partial sums are never exposed while BUSY.
   assign dataout   = out_valid ? acc_q[DBLEN23-1:0] : '0;
   assign code_err  = out_valid & (|acc_q[ACC_W-1:DBLEN23]);

endmodule
